hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised successor to the register-number equality compare in the pipelined CPU.
- Tracks the destination registers of in-flight instructions in a shift pipeline of DEPTH stages. Compares every decode-stage source register against all of them in parallel.
- Produces per-source forwarding selects, a load-use / no-forward stall, and a saturating stall-cycle counter.
- Sits between decode and the operand-forwarding muxes, and drives the hazard stall to the fetch/decode pipeline registers.

Parameters:
- REG_W, 5, register address width.
- DEPTH, 3, number of tracked in-flight stages (entry 0 = EX, 1 = MEM, 2 = WB).
- NUM_SRC, 2, number of source operands checked per cycle.
- ZERO_REG, 31, register index that never creates a hazard (XZR).
- FWD_EN, 1, 1 = forwarding mode, 0 = stall-only mode.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- issue_valid  in  1  decode holds a valid instruction.
- issue_wen  in  1  instruction writes a register.
- issue_rd  in  REG_W  destination register.
- issue_is_load  in  1  instruction is a load.
- src_valid  in  NUM_SRC  per-source "operand is read".
- src_addr  in  NUM_SRC*REG_W  source registers; source i is at bits [i*REG_W +: REG_W].
- flush  in  1  squash all tracked entries (branch taken).
- fwd_sel  out  NUM_SRC*SEL_W  per-source select. SEL_W = $clog2(DEPTH+1). 0 = register file; k = forward from entry k-1.
- stall  out  1  hold decode and fetch, and insert a bubble.
- stall_cnt  out  CNT_W  saturating count of stall cycles.

Behaviour:
- State: DEPTH entries, each {valid, rd, is_load}, plus stall_cnt.
- Reset (reset = 0, asynchronous):
  - All entry valid bits clear; stall_cnt = 0.
  - Because no entry is valid, fwd_sel = 0 and stall = 0 for any inputs.
- Entry write condition: ent_wr = issue_valid & issue_wen & (issue_rd != ZERO_REG) & ~stall.
- Each rising edge with reset = 1:
  - If flush: all entries invalid; stall_cnt updates as normal.
  - Else:
    - entry[k] <= entry[k-1] for k = 1..DEPTH-1.
    - entry[0] <= {ent_wr, issue_rd, issue_is_load}. A stalled or non-writing instruction inserts a bubble (valid = 0).
    - The oldest entry is dropped.
- Match (combinational): match[i][k] = src_valid[i] & (src_addr[i] != ZERO_REG) & entry[k].valid & (entry[k].rd == src_addr[i]).
- FWD_EN = 1:
  - fwd_sel[i] = 1 + index of the youngest (lowest k) matching entry; 0 if no match.
  - stall = OR over i of (youngest match for source i is entry 0 and entry[0].is_load) — the load-use hazard.
  - An older match does not stall.
  - When stall is asserted, fwd_sel is still driven but is don't-care downstream.
- FWD_EN = 0:
  - fwd_sel is held at 0.
  - stall = OR over all i, k of match[i][k].
- Gating: stall and fwd_sel are gated by issue_valid. When issue_valid = 0, stall = 0 and fwd_sel = 0.
- stall_cnt: increments on each rising edge where stall = 1 and flush = 0. Holds at 2^CNT_W - 1.
- Simultaneous flush and stall: flush wins. Entries clear, no bubble logic applies, and the counter does not increment.
- Latency:
  - Compares: zero cycles, combinational from registered entries and inputs.
  - Entry insertion: one cycle.
- A load-use pair stalls exactly one cycle with DEPTH >= 2. The next cycle the load sits in entry 1 and fwd_sel = 2.
- Reset asserted mid-stall: stall drops immediately (asynchronous clear of valid bits).

Test Plan:
- Reset, then issue ADD X3 (wen) followed by ADD using src0 = X3 -> cycle 2: fwd_sel[0] = 1, stall = 0. Next cycle with src0 = X3 again -> fwd_sel[0] = 2.
- LDR X5, then SUB with src1 = X5 -> stall = 1 for one cycle, bubble enters entry 0, then fwd_sel[1] = 2, stall = 0, stall_cnt = 1.
- Writes to X7 in consecutive cycles (entries 0 and 1 both X7), src0 = X7 -> fwd_sel[0] = 1 (youngest wins). Same case with src0 = X31 -> fwd_sel[0] = 0.
- Flush asserted in the same cycle as a load-use stall -> all entries invalid the next cycle, fwd_sel = 0, stall = 0, stall_cnt unchanged.
- FWD_EN = 0, DEPTH = 3: ADD X2, then dependent src0 = X2 -> stall = 1 for 3 cycles, then 0; fwd_sel stays 0; stall_cnt = 3.
- CNT_W = 2 with sustained stalls -> stall_cnt saturates at 3. Pulling reset low mid-stall -> stall = 0 and stall_cnt = 0 without waiting for a clock edge.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: tracks in-flight destination registers and resolves decode-stage
// operand hazards into forwarding selects, a stall, and a saturating stall counter.
module hazard_scoreboard #(
  parameter int REG_W = 5,
  parameter int DEPTH = 3,
  parameter int NUM_SRC = 2,
  parameter int ZERO_REG = 31,
  parameter int FWD_EN = 1,
  parameter int CNT_W = 16,
  localparam int SEL_W = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     issue_valid,
  input  logic                     issue_wen,
  input  logic [REG_W-1:0]         issue_rd,
  input  logic                     issue_is_load,
  input  logic [NUM_SRC-1:0]       src_valid,
  input  logic [NUM_SRC*REG_W-1:0] src_addr,
  input  logic                     flush,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [CNT_W-1:0]         stall_cnt
);
  logic [DEPTH-1:0] ent_v, ent_ld;
  logic [DEPTH-1:0][REG_W-1:0] ent_rd;
  logic [NUM_SRC-1:0][SEL_W-1:0] sel;
  logic [NUM_SRC-1:0] hit, ld_use;
  logic ent_wr;
  // scanning oldest to youngest lets the youngest match overwrite older ones
  always_comb begin
    sel = '0;
    hit = '0;
    ld_use = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = DEPTH - 1; k >= 0; k--)
        if (src_valid[i] && src_addr[i*REG_W +: REG_W] != REG_W'(ZERO_REG) && ent_v[k] &&
            ent_rd[k] == src_addr[i*REG_W +: REG_W])
          sel[i] = SEL_W'(k + 1);
      hit[i] = sel[i] != '0;
      ld_use[i] = sel[i] == SEL_W'(1) && ent_ld[0];
    end
  end
  assign stall = issue_valid & (FWD_EN != 0 ? |ld_use : |hit);
  assign fwd_sel = (issue_valid && FWD_EN != 0) ? sel : '0;
  assign ent_wr = issue_valid & issue_wen & (issue_rd != REG_W'(ZERO_REG)) & ~stall;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      ent_v <= '0;
      ent_ld <= '0;
      ent_rd <= '0;
      stall_cnt <= '0;
    end else begin
      if (flush) ent_v <= '0;
      else begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          ent_v[k] <= ent_v[k-1];
          ent_ld[k] <= ent_ld[k-1];
          ent_rd[k] <= ent_rd[k-1];
        end
        ent_v[0] <= ent_wr;
        ent_ld[0] <= issue_is_load;
        ent_rd[0] <= issue_rd;
      end
      if (stall && !flush && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: three configurations (forwarding, stall-only, stall-only with 2-bit
// counter) driven by one directed stream and checked every cycle against an in-flight model.
module tb_hazard_scoreboard;
  logic clk = 0, reset = 1, issue_valid = 0, issue_wen = 0, issue_is_load = 0, flush = 0;
  logic [4:0] issue_rd = '0;
  logic [1:0] src_valid = '0;
  logic [9:0] src_addr = '0;
  logic [3:0] f0, f1, f2;
  logic s0, s1, s2;
  logic [15:0] c0, c1;
  logic [1:0] c2;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;

  hazard_scoreboard u0 (.clk(clk), .reset(reset), .issue_valid(issue_valid), .issue_wen(issue_wen),
    .issue_rd(issue_rd), .issue_is_load(issue_is_load), .src_valid(src_valid), .src_addr(src_addr),
    .flush(flush), .fwd_sel(f0), .stall(s0), .stall_cnt(c0));
  hazard_scoreboard #(.FWD_EN(0)) u1 (.clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_is_load(issue_is_load), .src_valid(src_valid),
    .src_addr(src_addr), .flush(flush), .fwd_sel(f1), .stall(s1), .stall_cnt(c1));
  hazard_scoreboard #(.FWD_EN(0), .CNT_W(2)) u2 (.clk(clk), .reset(reset), .issue_valid(issue_valid),
    .issue_wen(issue_wen), .issue_rd(issue_rd), .issue_is_load(issue_is_load), .src_valid(src_valid),
    .src_addr(src_addr), .flush(flush), .fwd_sel(f2), .stall(s2), .stall_cnt(c2));

  logic [3:0] af[3];
  logic as_[3];
  int ac[3];
  assign af[0] = f0;
  assign af[1] = f1;
  assign af[2] = f2;
  assign as_[0] = s0;
  assign as_[1] = s1;
  assign as_[2] = s2;
  assign ac[0] = int'(c0);
  assign ac[1] = int'(c1);
  assign ac[2] = int'(c2);

  // model: per configuration, youngest-first list of in-flight writes and a stall count
  int fe[3] = '{1, 0, 0};
  int cmax[3] = '{65535, 65535, 3};
  bit [2:0] mv[3];
  bit [2:0] mld[3];
  logic [2:0][4:0] mrd[3];
  int mcnt[3] = '{0, 0, 0};

  function automatic void exp_out(input int m, output logic [3:0] sel, output logic st);
    sel = '0;
    st = 0;
    if (issue_valid)
      for (int i = 0; i < 2; i++) begin
        int a;
        int y;
        a = int'(src_addr[i*5 +: 5]);
        y = -1;
        for (int k = 0; k < 3; k++)
          if (y < 0 && src_valid[i] && a != 31 && mv[m][k] && int'(mrd[m][k]) == a) y = k;
        if (fe[m] == 1) begin
          if (y >= 0) sel[i*2 +: 2] = 2'(y + 1);
          if (y == 0 && mld[m][0]) st = 1;
        end else if (y >= 0) st = 1;
      end
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  logic [3:0] ms;
  logic mst;
  always @(posedge clk or negedge reset)
    if (!reset)
      for (int m = 0; m < 3; m++) begin
        mv[m] <= '0;
        mcnt[m] <= 0;
      end
    else
      for (int m = 0; m < 3; m++) begin
        exp_out(m, ms, mst);
        if (flush) mv[m] <= '0;
        else begin
          mv[m] <= {mv[m][1:0], issue_valid && issue_wen && issue_rd != 5'd31 && !mst};
          mld[m] <= {mld[m][1:0], issue_is_load};
          mrd[m] <= {mrd[m][1:0], issue_rd};
        end
        if (mst && !flush && mcnt[m] < cmax[m]) mcnt[m] <= mcnt[m] + 1;
      end

  logic [3:0] cs;
  logic cst;
  always @(negedge clk)
    for (int m = 0; m < 3; m++) begin
      exp_out(m, cs, cst);
      chk($sformatf("model_fwd%0d", m), int'(af[m]), int'(cs));
      chk($sformatf("model_stall%0d", m), int'(as_[m]), int'(cst));
      chk($sformatf("model_cnt%0d", m), ac[m], mcnt[m]);
    end

  task automatic drv(input logic v, input logic wen, input int rd, input logic ld,
                     input logic [1:0] sv, input int a0, input int a1, input logic fl);
    @(posedge clk);
    #1;
    issue_valid = v;
    issue_wen = wen;
    issue_rd = 5'(rd);
    issue_is_load = ld;
    src_valid = sv;
    src_addr = {5'(a1), 5'(a0)};
    flush = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(0, 0, 0, 0, 2'b00, 0, 0, 0);
  endtask

  initial begin
    #1 reset = 0;
    #21 reset = 1;
    @(negedge clk);
    chk("rst_stall", s0, 0);
    chk("rst_fwd", f0, 0);
    chk("rst_cnt", c0, 0);
    drv(1, 1, 3, 0, 2'b00, 0, 0, 0);
    drv(1, 1, 4, 0, 2'b01, 3, 0, 0);
    @(negedge clk);
    chk("fwd_ex", f0[1:0], 1);
    chk("alu_no_stall", s0, 0);
    drv(1, 0, 0, 0, 2'b01, 3, 0, 0);
    @(negedge clk);
    chk("fwd_mem", f0[1:0], 2);
    idle(3);
    drv(1, 1, 5, 1, 2'b00, 0, 0, 0);
    drv(1, 1, 6, 0, 2'b10, 0, 5, 0);
    @(negedge clk);
    chk("ld_use_stall", s0, 1);
    drv(1, 1, 6, 0, 2'b10, 0, 5, 0);
    @(negedge clk);
    chk("ld_use_release", s0, 0);
    chk("fwd_after_bubble", f0[3:2], 2);
    chk("cnt_one", c0, 1);
    idle(3);
    drv(1, 1, 7, 0, 2'b00, 0, 0, 0);
    drv(1, 1, 7, 0, 2'b00, 0, 0, 0);
    drv(1, 0, 0, 0, 2'b11, 7, 31, 0);
    @(negedge clk);
    chk("youngest_wins", f0[1:0], 1);
    chk("zero_reg", f0[3:2], 0);
    idle(3);
    drv(1, 1, 5, 1, 2'b00, 0, 0, 0);
    drv(1, 1, 6, 0, 2'b10, 0, 5, 1);
    @(negedge clk);
    chk("flush_stall_comb", s0, 1);
    drv(1, 1, 6, 0, 2'b10, 0, 5, 0);
    @(negedge clk);
    chk("flush_clear_stall", s0, 0);
    chk("flush_clear_fwd", f0, 0);
    chk("flush_cnt_hold", c0, 1);
    idle(3);
    @(negedge clk);
    #2 reset = 0;
    #2 reset = 1;
    drv(1, 1, 2, 0, 2'b00, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      drv(1, 1, 8, 0, 2'b01, 2, 0, 0);
      @(negedge clk);
      chk("nofwd_stall", s1, int'(c < 3));
      chk("nofwd_sel", f1, 0);
    end
    chk("nofwd_cnt3", c1, 3);
    chk("cnt2_three", c2, 3);
    for (int c = 0; c < 4; c++) begin
      drv(1, 1, 8, 0, 2'b01, 8, 0, 0);
      @(negedge clk);
      chk("nofwd_stall2", s2, int'(c < 3));
    end
    chk("sat_cnt", c2, 3);
    chk("nofwd_cnt6", c1, 6);
    drv(1, 0, 0, 0, 2'b01, 8, 0, 0);
    @(negedge clk);
    chk("pre_rst_stall", s2, 1);
    #2 reset = 0;
    #1;
    chk("async_rst_stall", s2, 0);
    chk("async_rst_stall1", s1, 0);
    chk("async_rst_cnt", c2, 0);
    #1 reset = 1;
    idle(2);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
